population_count_sequential: RTL

Multi-cycle population counter that counts ones or zeros in a DATA_WIDTH-bit operand.
- Processes CHUNK_WIDTH bits per clock, trading latency for area against the fully combinational counter.
- Terminates early once no set bits remain in the unprocessed part of the operand.
- Sits beside the other integer miscellaneous units and talks to the datapath through a valid/ready request port and a one-cycle result strobe.

---
 rtl/population_count_sequential_if.sv | 24 ++
 rtl/population_count_sequential.sv | 109 ++++++++++
 2 files changed

// File: rtl/population_count_sequential_if.sv
// Request/result port of the sequential population counter: valid/ready request in,
// registered count out with a one-cycle result strobe.
interface population_count_sequential_if #(
   parameter int DATA_WIDTH = 32
);
   localparam int COUNT_WIDTH = $clog2(DATA_WIDTH) + 1;

   logic [DATA_WIDTH-1:0]  operand_i;
   logic                   mode_i;
   logic                   valid_i;
   logic                   ready_o;
   logic [COUNT_WIDTH-1:0] count_o;
   logic                   valid_o;

   modport master (
      output operand_i, mode_i, valid_i,
      input  ready_o, count_o, valid_o
   );

   modport slave (
      input  operand_i, mode_i, valid_i,
      output ready_o, count_o, valid_o
   );
endinterface

// File: rtl/population_count_sequential.sv
// Counts ones (or zeros) CHUNK_WIDTH bits per cycle, stopping once the remainder is zero.
// Latency 1..CHUNKS edges after accept; ready only in IDLE, requests while busy are ignored.
module population_count_sequential #(
   parameter int DATA_WIDTH  = 32,
   parameter int CHUNK_WIDTH = 8
) (
   input  logic                         clk_i,
   input  logic                         rst_n_i,
   population_count_sequential_if.slave bus
);
   localparam int CHUNKS          = DATA_WIDTH / CHUNK_WIDTH;
   localparam int COUNT_WIDTH     = $clog2(DATA_WIDTH) + 1;
   localparam int CHUNK_IDX_WIDTH = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam logic [CHUNK_IDX_WIDTH-1:0] LAST_CHUNK = CHUNK_IDX_WIDTH'(CHUNKS - 1);

   generate
      if (DATA_WIDTH < 1 || CHUNK_WIDTH < 1 || CHUNK_WIDTH > DATA_WIDTH ||
          (DATA_WIDTH & (DATA_WIDTH - 1)) != 0 ||
          (CHUNK_WIDTH & (CHUNK_WIDTH - 1)) != 0 ||
          (DATA_WIDTH % CHUNK_WIDTH) != 0) begin : g_bad_params
         $error("population_count_sequential: illegal DATA_WIDTH/CHUNK_WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE,
      COUNT,
      DONE
   } state_t;

   state_t                     state_q, state_d;
   logic [DATA_WIDTH-1:0]      shift_q, shift_d, remainder;
   logic [COUNT_WIDTH-1:0]     acc_q, acc_d;
   logic [COUNT_WIDTH-1:0]     count_q, count_d;
   logic [COUNT_WIDTH-1:0]     chunk_ones, sum;
   logic [CHUNK_IDX_WIDTH-1:0] chunk_q, chunk_d;
   logic                       valid_q, valid_d;

   always_comb begin
      chunk_ones = '0;
      for (int i = 0; i < CHUNK_WIDTH; i++) begin
         chunk_ones = chunk_ones + COUNT_WIDTH'(shift_q[i]);
      end
   end

   assign sum = acc_q + chunk_ones;

   // A single-chunk operand has nothing left after its one counting cycle.
   generate
      if (CHUNK_WIDTH == DATA_WIDTH) begin : g_single
         assign remainder = '0;
      end else begin : g_multi
         assign remainder = {{CHUNK_WIDTH{1'b0}}, shift_q[DATA_WIDTH-1:CHUNK_WIDTH]};
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      acc_d   = acc_q;
      chunk_d = chunk_q;
      count_d = count_q;
      valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.valid_i) begin
               shift_d = bus.mode_i ? ~bus.operand_i : bus.operand_i;
               acc_d   = '0;
               chunk_d = '0;
               state_d = COUNT;
            end
         end
         COUNT: begin
            acc_d   = sum;
            shift_d = remainder;
            chunk_d = chunk_q + CHUNK_IDX_WIDTH'(1);
            if (remainder == '0 || chunk_q == LAST_CHUNK) begin
               count_d = sum;
               valid_d = 1'b1;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         shift_q <= '0;
         acc_q   <= '0;
         chunk_q <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         acc_q   <= acc_d;
         chunk_q <= chunk_d;
         count_q <= count_d;
         valid_q <= valid_d;
      end
   end

   assign bus.ready_o = (state_q == IDLE);
   assign bus.count_o = count_q;
   assign bus.valid_o = valid_q;
endmodule
